// File: rtl/grant_index_arbiter_pkg.sv
// Shared definitions for the eight-way round-robin grant-index arbiter.
package grant_index_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Width of the hold counter: enough to count up to max_hold, never below 1 bit.
    function automatic int hold_cnt_w(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/grant_index_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0, take the
// lowest set bit, then add ptr back to recover the absolute requester index.
module grant_index_arbiter_rr_pick
    import grant_index_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any_req
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   rot_idx;

    assign req_dbl = {req, req};
    assign rot     = req_dbl[ptr +: N_REQ];
    assign any_req = |rot;

    // Fixed-priority encode of the rotated vector; scanning downwards lets bit 0 win.
    always_comb begin
        rot_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                rot_idx = IDX_W'(j);
            end
        end
    end

    // Un-rotate; the 3-bit add wraps modulo 8 naturally.
    assign idx = rot_idx + ptr;

endmodule

// File: rtl/grant_index_arbiter.sv
// Round-robin arbiter for eight requesters with a registered grant index,
// hold-while-requested ownership and an optional hold-time limit.
module grant_index_arbiter
    import grant_index_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             preempt
);

    localparam int                HOLD_W    = hold_cnt_w(MAX_HOLD);
    localparam logic              LIMITED   = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              any_req;
    logic              owner_req;
    logic              hold_expired;

    grant_index_arbiter_rr_pick u_pick (
        .req     (req),
        .ptr     (ptr),
        .idx     (pick_idx),
        .any_req (any_req)
    );

    assign owner_req    = req[grant_idx];
    assign hold_expired = LIMITED && (hold_cnt == HOLD_LAST);

    // FSM, rotation pointer, hold counter and output registers; preempt is a
    // one-cycle pulse raised only when the owner still wants the bus at expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            preempt     <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_expired) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant_idx + IDX_W'(1);
                        preempt     <= owner_req;
                        state       <= IDLE;
                    end else if (LIMITED && (hold_cnt != '1)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_index_arbiter.sv
// Directed bench for grant_index_arbiter: a vector table on a default instance
// plus hand-written sequences for reset, fairness, preemption and unlimited hold.
module tb_grant_index_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req, reqp, requ;
    logic [2:0] gi, gip, giu;
    logic       gv, gvp, gvu;
    logic       pe, pep, peu;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] req;
        logic       v;
        logic [2:0] idx;
        logic       p;
    } vec_t;

    vec_t tbl[16];

    grant_index_arbiter #(.MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant_idx(gi), .grant_valid(gv), .preempt(pe)
    );

    grant_index_arbiter #(.MAX_HOLD(4)) dutp (
        .clk(clk), .rst_n(rst_n), .req(reqp),
        .grant_idx(gip), .grant_valid(gvp), .preempt(pep)
    );

    grant_index_arbiter #(.MAX_HOLD(0)) dutu (
        .clk(clk), .rst_n(rst_n), .req(requ),
        .grant_idx(giu), .grant_valid(gvu), .preempt(peu)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic v, input logic [2:0] i, input logic p,
                        input logic ev, input logic [2:0] ei, input logic ep);
        chk({name, ".valid"}, int'(v), int'(ev));
        if (ev) chk({name, ".idx"}, int'(i), int'(ei));
        chk({name, ".preempt"}, int'(p), int'(ep));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table for the default instance: {req, valid, idx, preempt} after each edge.
        tbl[0]  = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{8'h24, 1'b1, 3'd2, 1'b0};
        tbl[3]  = '{8'h24, 1'b1, 3'd2, 1'b0};
        tbl[4]  = '{8'h20, 1'b0, 3'd2, 1'b0};
        tbl[5]  = '{8'h20, 1'b1, 3'd5, 1'b0};
        tbl[6]  = '{8'hA0, 1'b1, 3'd5, 1'b0};
        tbl[7]  = '{8'h80, 1'b0, 3'd5, 1'b0};
        tbl[8]  = '{8'h81, 1'b1, 3'd7, 1'b0};
        tbl[9]  = '{8'h81, 1'b1, 3'd7, 1'b0};
        tbl[10] = '{8'h01, 1'b0, 3'd7, 1'b0};
        tbl[11] = '{8'h81, 1'b1, 3'd0, 1'b0};
        tbl[12] = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{8'h01, 1'b1, 3'd0, 1'b0};
        tbl[15] = '{8'h00, 1'b0, 3'd0, 1'b0};

        rst_n = 1'b1;
        req   = 8'h00;
        reqp  = 8'h00;
        requ  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.idx", int'(gi), 0);
        chk("rst.valid", int'(gv), 0);
        chk("rst.preempt", int'(pe), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Vector table: every field is compared, including idx holding after release.
        for (int k = 0; k < 16; k++) begin
            req = tbl[k].req;
            tick();
            chk($sformatf("tbl%0d.valid", k), int'(gv), int'(tbl[k].v));
            chk($sformatf("tbl%0d.idx", k), int'(gi), int'(tbl[k].idx));
            chk($sformatf("tbl%0d.preempt", k), int'(pe), int'(tbl[k].p));
        end

        // Reset asserted mid-grant clears outputs without waiting for a clock edge.
        req = 8'h08;
        tick();
        chk3("rstmid.pre", gv, gi, pe, 1'b1, 3'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.idx", int'(gi), 0);
        chk("rstmid.valid", int'(gv), 0);
        chk("rstmid.preempt", int'(pe), 0);
        tick();
        chk3("rstmid.hold", gv, gi, pe, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        req = 8'h00;
        tick();
        chk3("rstmid.after", gv, gi, pe, 1'b0, 3'd0, 1'b0);

        // Fairness: all requesting, each owner drops after three granted cycles.
        for (int k = 0; k < 9; k++) begin
            req = 8'hFF;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk3($sformatf("fair%0d.c%0d", k, c), gv, gi, pe, 1'b1, 3'(k % 8), 1'b0);
            end
            req = 8'hFF & ~(8'h01 << (k % 8));
            tick();
            chk3($sformatf("fair%0d.gap", k), gv, gi, pe, 1'b0, 3'd0, 1'b0);
        end
        req = 8'h00;

        // MAX_HOLD=4: sole requester 3 is preempted then re-granted.
        reqp = 8'h08;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk3($sformatf("pre.a%0d", c), gvp, gip, pep, 1'b1, 3'd3, 1'b0);
        end
        tick();
        chk3("pre.a.pulse", gvp, gip, pep, 1'b0, 3'd0, 1'b1);
        tick();
        chk3("pre.regrant3", gvp, gip, pep, 1'b1, 3'd3, 1'b0);
        reqp = 8'h0A;
        for (int c = 1; c < 4; c++) begin
            tick();
            chk3($sformatf("pre.b%0d", c), gvp, gip, pep, 1'b1, 3'd3, 1'b0);
        end
        tick();
        chk3("pre.b.pulse", gvp, gip, pep, 1'b0, 3'd0, 1'b1);
        tick();
        chk3("pre.next1", gvp, gip, pep, 1'b1, 3'd1, 1'b0);
        reqp = 8'h00;
        tick();
        chk3("pre.rel1", gvp, gip, pep, 1'b0, 3'd0, 1'b0);

        // MAX_HOLD=0: requester 6 keeps the grant for 100 cycles, no preempt.
        requ = 8'h40;
        tick();
        chk3("unl.grant", gvu, giu, peu, 1'b1, 3'd6, 1'b0);
        begin
            int bad_cycles;
            bad_cycles = 0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (!gvu || giu != 3'd6 || peu) bad_cycles++;
            end
            chk("unl.held100", bad_cycles, 0);
        end
        requ = 8'h00;
        tick();
        chk3("unl.rel", gvu, giu, peu, 1'b0, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
